// File: rtl/switch_key_input.sv
// Bus-mapped input port: synchronizes and debounces 32 DIP switches and 8 keys,
// latches key presses as sticky events and raises a level interrupt while any are pending.
module switch_key_input #(
    parameter logic [31:0] BASE       = 32'h0000_7F60,
    parameter logic [19:0] DEB_CYCLES = 20'd500000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] Address,
    input  logic [31:0] WD,
    input  logic [3:0]  WE,
    output logic [31:0] RD,
    input  logic [31:0] dip_switch,
    input  logic [7:0]  user_key,
    output logic        irq
);

    logic [31:0] sw_sync1, sw_sync2, sw_cand, sw_stab;
    logic [19:0] sw_cnt;
    logic [7:0]  key_sync1, key_sync2, key_cand, key_stab;
    logic [19:0] key_cnt;
    logic [7:0]  pending;
    logic        irq_en;

    logic [31:0] sw_cand_next, sw_stab_next;
    logic [19:0] sw_cnt_next;
    logic [7:0]  key_cand_next, key_stab_next;
    logic [19:0] key_cnt_next;
    logic [7:0]  rise, clr, pending_next;
    logic        irq_en_next;

    logic        hit, evt_wr, ctrl_wr;
    logic [1:0]  sel;
    logic        unused_bits;

    assign hit         = (Address[31:4] == BASE[31:4]);
    assign sel         = Address[3:2];
    assign evt_wr      = hit && (sel == 2'd2) && WE[0];
    assign ctrl_wr     = hit && (sel == 2'd3) && WE[0];
    assign unused_bits = ^{Address[1:0], WE[3:1], WD[31:8]};

    // Switch group: all 32 bits share one counter, so any change restarts the window.
    always_comb begin
        sw_cand_next = sw_cand;
        sw_stab_next = sw_stab;
        sw_cnt_next  = sw_cnt;
        if (sw_sync2 != sw_cand) begin
            sw_cand_next = sw_sync2;
            sw_cnt_next  = 20'd0;
        end else if (sw_cand != sw_stab) begin
            if (sw_cnt == DEB_CYCLES - 20'd1) begin
                sw_stab_next = sw_cand;
                sw_cnt_next  = 20'd0;
            end else begin
                sw_cnt_next = sw_cnt + 20'd1;
            end
        end else begin
            sw_cnt_next = 20'd0;
        end
    end

    always_comb begin
        key_cand_next = key_cand;
        key_stab_next = key_stab;
        key_cnt_next  = key_cnt;
        if (key_sync2 != key_cand) begin
            key_cand_next = key_sync2;
            key_cnt_next  = 20'd0;
        end else if (key_cand != key_stab) begin
            if (key_cnt == DEB_CYCLES - 20'd1) begin
                key_stab_next = key_cand;
                key_cnt_next  = 20'd0;
            end else begin
                key_cnt_next = key_cnt + 20'd1;
            end
        end else begin
            key_cnt_next = 20'd0;
        end
    end

    // A press landing on the same edge as its clear survives: rise is OR-ed after masking.
    always_comb begin
        rise         = key_stab_next & ~key_stab;
        clr          = evt_wr ? WD[7:0] : 8'd0;
        pending_next = (pending & ~clr) | rise;
        irq_en_next  = ctrl_wr ? WD[0] : irq_en;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sw_sync1  <= '0;
            sw_sync2  <= '0;
            sw_cand   <= '0;
            sw_stab   <= '0;
            sw_cnt    <= '0;
            key_sync1 <= '0;
            key_sync2 <= '0;
            key_cand  <= '0;
            key_stab  <= '0;
            key_cnt   <= '0;
            pending   <= '0;
            irq_en    <= 1'b0;
            irq       <= 1'b0;
        end else begin
            sw_sync1  <= dip_switch;
            sw_sync2  <= sw_sync1;
            sw_cand   <= sw_cand_next;
            sw_stab   <= sw_stab_next;
            sw_cnt    <= sw_cnt_next;
            key_sync1 <= user_key;
            key_sync2 <= key_sync1;
            key_cand  <= key_cand_next;
            key_stab  <= key_stab_next;
            key_cnt   <= key_cnt_next;
            pending   <= pending_next;
            irq_en    <= irq_en_next;
            irq       <= irq_en_next & (|pending_next);
        end
    end

    always_comb begin
        RD = 32'd0;
        if (hit) begin
            case (sel)
                2'd0:    RD = sw_stab;
                2'd1:    RD = {24'd0, key_stab};
                2'd2:    RD = {24'd0, pending};
                default: RD = {31'd0, irq_en};
            endcase
        end
    end

endmodule

// File: tb/tb_switch_key_input.sv
// Directed bench for switch_key_input with a short debounce window (DEB_CYCLES=4).
module tb_switch_key_input;

    localparam logic [31:0] A_SW   = 32'h0000_7F60;
    localparam logic [31:0] A_KEY  = 32'h0000_7F64;
    localparam logic [31:0] A_EVT  = 32'h0000_7F68;
    localparam logic [31:0] A_CTRL = 32'h0000_7F6C;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] Address, WD, RD, dip_switch;
    logic [3:0]  WE;
    logic [7:0]  user_key;
    logic        irq;

    int n_checks = 0;
    int n_errors = 0;

    switch_key_input #(.BASE(32'h0000_7F60), .DEB_CYCLES(20'd4)) dut (
        .clk(clk), .reset(reset), .Address(Address), .WD(WD), .WE(WE), .RD(RD),
        .dip_switch(dip_switch), .user_key(user_key), .irq(irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk_rd(input string tag, input logic [31:0] a, input logic [31:0] exp);
        Address = a;
        #1;
        chk(tag, RD, exp);
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] we);
        Address = a;
        WD      = d;
        WE      = we;
        @(posedge clk);
        #1;
        WE = 4'b0000;
        WD = 32'd0;
    endtask

    initial begin
        reset      = 1'b1;
        Address    = 32'd0;
        WD         = 32'd0;
        WE         = 4'b0000;
        dip_switch = 32'd0;
        user_key   = 8'd0;
        step(3);
        reset = 1'b0;

        chk_rd("rst_sw", A_SW, 32'd0);
        chk_rd("rst_key", A_KEY, 32'd0);
        chk_rd("rst_evt", A_EVT, 32'd0);
        chk_rd("rst_ctrl", A_CTRL, 32'd0);
        chk("rst_irq", {31'd0, irq}, 32'd0);

        // Switch latency: stable value appears after edge 3+DEB_CYCLES = 7
        dip_switch = 32'hA5A5_0F0F;
        for (int k = 1; k <= 8; k++) begin
            step(1);
            chk_rd($sformatf("sw_edge%0d", k), A_SW, (k >= 7) ? 32'hA5A5_0F0F : 32'd0);
        end
        chk_rd("miss_hi", 32'h0000_7F70, 32'd0);
        chk_rd("miss_far", 32'h0001_7F60, 32'd0);
        wr(A_SW, 32'hFFFF_FFFF, 4'b1111);
        chk_rd("sw_ro", A_SW, 32'hA5A5_0F0F);

        // 3-cycle glitch on key 2 is filtered
        user_key = 8'h04;
        step(3);
        user_key = 8'h00;
        step(10);
        chk_rd("glitch_key", A_KEY, 32'd0);
        chk_rd("glitch_evt", A_EVT, 32'd0);

        user_key = 8'h04;
        step(10);
        chk_rd("hold_key", A_KEY, 32'h04);
        chk_rd("hold_evt", A_EVT, 32'h04);
        chk("irq_dis", {31'd0, irq}, 32'd0);
        user_key = 8'h00;
        step(10);
        chk_rd("rel_key", A_KEY, 32'd0);
        chk_rd("rel_evt", A_EVT, 32'h04);

        wr(A_CTRL, 32'd1, 4'b0001);
        chk("irq_on", {31'd0, irq}, 32'd1);
        chk_rd("ctrl_rd", A_CTRL, 32'd1);
        wr(A_EVT, 32'h04, 4'b0010);
        chk_rd("evt_we1", A_EVT, 32'h04);
        chk("irq_we1", {31'd0, irq}, 32'd1);
        wr(A_EVT, 32'h04, 4'b0001);
        chk("irq_clr", {31'd0, irq}, 32'd0);
        chk_rd("evt_clr", A_EVT, 32'd0);

        // Key 0 rise lands on edge 7, the same edge as a W1C write of bit 0
        user_key = 8'h01;
        step(6);
        chk_rd("evt_pre", A_EVT, 32'd0);
        wr(A_EVT, 32'h01, 4'b0001);
        chk_rd("set_wins", A_EVT, 32'h01);
        chk("irq_set", {31'd0, irq}, 32'd1);
        wr(A_CTRL, 32'd0, 4'b0001);
        chk("irq_en0", {31'd0, irq}, 32'd0);
        wr(A_CTRL, 32'd1, 4'b0001);
        chk("irq_en1", {31'd0, irq}, 32'd1);
        user_key = 8'h00;
        step(10);
        chk_rd("rel0_evt", A_EVT, 32'h01);

        // Asynchronous reset in the middle of a switch debounce
        dip_switch = 32'h1234_5678;
        step(5);
        #2;
        reset = 1'b1;
        #1;
        chk("arst_irq", {31'd0, irq}, 32'd0);
        chk_rd("arst_sw", A_SW, 32'd0);
        chk_rd("arst_evt", A_EVT, 32'd0);
        chk_rd("arst_ctrl", A_CTRL, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            step(1);
            chk_rd($sformatf("rsw_edge%0d", k), A_SW, (k >= 7) ? 32'h1234_5678 : 32'd0);
        end
        chk_rd("post_evt", A_EVT, 32'd0);
        chk("post_irq", {31'd0, irq}, 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
